des128_stream_ctrl: RTL and testbench

- Upstream sequencer for the 128-bit DES core: accepts plaintext/key pairs over a valid/ready handshake and holds them stable on the core inputs.
- Pulses the core reset to start each operation, then waits for the core's Done.
- Captures the ciphertext and presents it downstream over a valid/ready handshake.
- Processes one operation at a time; the input and output registers form the only buffering.

---
 rtl/des128_pkg.sv | 15 +
 rtl/des128_edge_det.sv | 21 ++
 rtl/des128_stream_ctrl.sv | 165 ++++++++++++++++
 tb/tb_des128_stream_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des128_pkg.sv
// Shared widths, FSM encoding and default parameters for the 128-bit DES stream controller.
package des128_pkg;

  localparam int DES128_W           = 128;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_START_PULSE    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/des128_edge_det.sv
// Single-bit rising-edge detector; the previous sample is cleared on a synchronous reset.
module des128_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/des128_stream_ctrl.sv
// Sequencer between a valid/ready stream and the 128-bit DES core: one operation at a time.
// Optional RUN timeout watchdog enabled by defining DES128_TIMEOUT_EN.
module des128_stream_ctrl
  import des128_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int START_PULSE    = DEF_START_PULSE
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DES128_W-1:0] in_plaintext,
  input  logic [DES128_W-1:0] in_key,
  output logic [DES128_W-1:0] core_plaintext,
  output logic [DES128_W-1:0] core_key,
  output logic                core_reset,
  input  logic                core_done,
  input  logic [DES128_W-1:0] core_ciphertext,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DES128_W-1:0] out_ciphertext,
  output logic                busy,
  output logic                timeout_err
);

  localparam int PW = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(START_PULSE - 1);

  if (START_PULSE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("des128_stream_ctrl: START_PULSE and TIMEOUT_CYCLES must be >= 1");
  end

  state_t              r_state;
  state_t              w_state_next;
  logic [PW-1:0]       r_pulse_cnt;
  logic [DES128_W-1:0] r_core_pt;
  logic [DES128_W-1:0] r_core_key;
  logic [DES128_W-1:0] r_out_ct;
  logic                w_accept;
  logic                w_capture;
  logic                w_timeout;
  logic                w_done_rise;

  des128_edge_det u_done_edge (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_d    (core_done),
    .o_rise (w_done_rise)
  );

`ifdef DES128_TIMEOUT_EN
  localparam int RW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT_CYCLES - 1);

  logic [RW-1:0] r_run_cnt;
  logic          r_timeout_err;
  logic          w_run_expired;

  assign w_run_expired = (r_run_cnt == RUN_LAST);
  assign timeout_err   = r_timeout_err;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_run_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == START) begin
        r_run_cnt <= '0;
      end else if (r_state == RUN) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end
`else
  logic w_run_expired;

  assign w_run_expired = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    in_ready     = 1'b0;
    core_reset   = 1'b1;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        // A real completion wins over a watchdog expiry in the same cycle.
        if (w_done_rise) begin
          w_capture    = 1'b1;
          w_state_next = HOLD;
        end else if (w_run_expired) begin
          w_timeout    = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pulse_cnt <= '0;
      r_core_pt   <= '0;
      r_core_key  <= '0;
      r_out_ct    <= '0;
    end else begin
      if (w_accept) begin
        r_core_pt   <= in_plaintext;
        r_core_key  <= in_key;
        r_pulse_cnt <= '0;
      end else if (r_state == START) begin
        r_pulse_cnt <= r_pulse_cnt + 1'b1;
      end
      if (w_capture) begin
        r_out_ct <= core_ciphertext;
      end else if (w_timeout) begin
        r_out_ct <= '0;
      end
    end
  end

  assign core_plaintext = r_core_pt;
  assign core_key       = r_core_key;
  assign out_ciphertext = r_out_ct;

endmodule

// File: tb/tb_des128_stream_ctrl.sv
// Directed bench for des128_stream_ctrl with a behavioural 16-cycle core (ciphertext = pt ^ key).
module tb_des128_stream_ctrl;

  localparam int LAT = 16;

  logic         Clk;
  logic         Reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plaintext;
  logic [127:0] in_key;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic         core_reset;
  logic         core_done;
  logic [127:0] core_ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ciphertext;
  logic         busy;
  logic         timeout_err;

  int n_pass;
  int n_total;

  logic [127:0] pt_tab  [10];
  logic [127:0] key_tab [10];

  // behavioural core model
  logic [7:0]   m_cnt;
  logic         m_done;
  logic [127:0] m_ct;
  bit           core_stall;
  bit           force_done;
  logic [127:0] force_ct;

  des128_stream_ctrl dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_plaintext    (in_plaintext),
    .in_key          (in_key),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_reset      (core_reset),
    .core_done       (core_done),
    .core_ciphertext (core_ciphertext),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_ciphertext  (out_ciphertext),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (core_reset) begin
      m_cnt  <= 8'd0;
      m_done <= 1'b0;
    end else if (!core_stall) begin
      if (m_cnt == 8'(LAT - 1)) begin
        m_done <= 1'b1;
        m_ct   <= core_plaintext ^ core_key;
      end else begin
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  assign core_done       = m_done | force_done;
  assign core_ciphertext = force_done ? force_ct : m_ct;

  task automatic wait_valid(input int max_cyc, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < max_cyc) begin
      @(negedge Clk);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic wait_run(output bit ok);
    int n;
    n = 0;
    while (core_reset && n < 50) begin
      @(negedge Clk);
      n++;
    end
    ok = !core_reset;
  endtask

  task automatic start_op(input logic [127:0] pt, input logic [127:0] key);
    in_plaintext = pt;
    in_key       = key;
    in_valid     = 1'b1;
    @(negedge Clk);
    in_valid     = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %0b want 1", core_reset); else n_pass++;
    n_total++; if (out_ciphertext !== 128'h0) $display("FAIL reset_out_ct: got %h want 0", out_ciphertext); else n_pass++;
    n_total++; if (core_plaintext !== 128'h0 || core_key !== 128'h0)
      $display("FAIL reset_core_inputs: got pt %h key %h want 0", core_plaintext, core_key); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); else n_pass++;
    $display("reset: in_ready=%0b out_valid=%0b busy=%0b core_reset=%0b", in_ready, out_valid, busy, core_reset);
  endtask

  task automatic test_single();
    int rst_hi, t_done, t_valid;
    logic [127:0] exp_ct;
    exp_ct     = pt_tab[0] ^ key_tab[0];
    core_stall = 1'b0;
    out_ready  = 1'b1;
    start_op(pt_tab[0], key_tab[0]);
    n_total++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL single_accept: got busy %0b in_ready %0b want 1/0", busy, in_ready); else n_pass++;
    n_total++; if (core_plaintext !== pt_tab[0] || core_key !== key_tab[0])
      $display("FAIL single_latch: got pt %h key %h want %h %h", core_plaintext, core_key, pt_tab[0], key_tab[0]); else n_pass++;
    rst_hi = 0;
    while (core_reset && rst_hi < 20) begin
      rst_hi++;
      @(negedge Clk);
    end
    n_total++; if (rst_hi !== 2) $display("FAIL single_core_reset_len: got %0d want 2", rst_hi); else n_pass++;
    t_done  = -1;
    t_valid = -1;
    for (int c = 0; c < 100; c++) begin
      if (t_done < 0 && core_done) t_done = c;
      if (out_valid) begin
        t_valid = c;
        break;
      end
      @(negedge Clk);
    end
    n_total++; if (t_done < 0 || t_valid - t_done !== 1)
      $display("FAIL single_done_latency: got done@%0d valid@%0d want gap 1", t_done, t_valid); else n_pass++;
    n_total++; if (out_ciphertext !== exp_ct) $display("FAIL single_ct: got %h want %h", out_ciphertext, exp_ct); else n_pass++;
    $display("single: ct=%h", out_ciphertext);
    @(negedge Clk);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL single_return_idle: got out_valid %0b in_ready %0b want 0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] exp1, exp2;
    exp1       = pt_tab[1] ^ key_tab[1];
    exp2       = pt_tab[2] ^ key_tab[2];
    core_stall = 1'b0;
    out_ready  = 1'b0;
    start_op(pt_tab[1], key_tab[1]);
    wait_valid(100, ok);
    n_total++; if (!ok) $display("FAIL bp_wait_valid: got no out_valid want 1 within 100 cycles"); else n_pass++;
    in_plaintext = pt_tab[2];
    in_key       = key_tab[2];
    in_valid     = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_total++; if (out_valid !== 1'b1 || out_ciphertext !== exp1 || in_ready !== 1'b0)
        $display("FAIL bp_hold_c%0d: got valid %0b ct %h in_ready %0b want 1 %h 0", c, out_valid, out_ciphertext, in_ready, exp1);
      else n_pass++;
      @(negedge Clk);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    n_total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: got busy %0b in_ready %0b valid %0b want 0 1 0", busy, in_ready, out_valid); else n_pass++;
    @(negedge Clk);
    in_valid = 1'b0;
    n_total++; if (busy !== 1'b1 || core_plaintext !== pt_tab[2])
      $display("FAIL bp_next_accept: got busy %0b pt %h want 1 %h", busy, core_plaintext, pt_tab[2]); else n_pass++;
    wait_valid(100, ok);
    n_total++; if (!ok || out_ciphertext !== exp2) $display("FAIL bp_second_ct: got %h want %h", out_ciphertext, exp2); else n_pass++;
    $display("backpressure: first=%h second=%h", exp1, out_ciphertext);
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int extra;
    core_stall = 1'b0;
    out_ready  = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int w;
          w = 0;
          in_plaintext = pt_tab[i];
          in_key       = key_tab[i];
          in_valid     = 1'b1;
          while (!in_ready && w < 200) begin
            @(negedge Clk);
            w++;
          end
          @(negedge Clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 10; j++) begin
          bit ok;
          logic [127:0] exp_ct;
          exp_ct = pt_tab[j] ^ key_tab[j];
          wait_valid(200, ok);
          n_total++; if (!ok || out_ciphertext !== exp_ct)
            $display("FAIL b2b_result%0d: got valid %0b ct %h want %h", j, ok, out_ciphertext, exp_ct);
          else n_pass++;
          $display("b2b: result %0d ct=%h", j, out_ciphertext);
          @(negedge Clk);
        end
      end
    join
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) extra++;
      @(negedge Clk);
    end
    n_total++; if (extra !== 0 || busy !== 1'b0)
      $display("FAIL b2b_no_extra: got %0d extra valid cycles busy %0b want 0 0", extra, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int seen;
    core_stall = 1'b1;
    out_ready  = 1'b1;
    start_op(pt_tab[3], key_tab[3]);
    wait_run(ok);
    n_total++; if (!ok) $display("FAIL rst_run_reach: got core_reset 1 want 0"); else n_pass++;
    repeat (7) @(negedge Clk);
    pulse_reset();
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0 || core_reset !== 1'b1)
      $display("FAIL rst_mid_state: got busy %0b valid %0b core_reset %0b want 0 0 1", busy, out_valid, core_reset); else n_pass++;
    n_total++; if (out_ciphertext !== 128'h0 || core_plaintext !== 128'h0)
      $display("FAIL rst_mid_clear: got ct %h pt %h want 0", out_ciphertext, core_plaintext); else n_pass++;
    force_ct   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    force_done = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (out_valid || busy) seen++;
    end
    force_done = 1'b0;
    n_total++; if (seen !== 0) $display("FAIL rst_late_done: got %0d active cycles want 0", seen); else n_pass++;
    $display("reset_mid_run: busy=%0b out_valid=%0b", busy, out_valid);
    core_stall = 1'b0;
  endtask

  task automatic test_spurious_done();
    bit ok;
    int n_valid;
    logic [127:0] cap;
    force_ct   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    force_done = 1'b1;
    @(negedge Clk);
    force_done = 1'b0;
    @(negedge Clk);
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_ciphertext !== 128'h0)
      $display("FAIL spur_idle: got busy %0b valid %0b ct %h want 0 0 0", busy, out_valid, out_ciphertext); else n_pass++;
    core_stall = 1'b1;
    out_ready  = 1'b1;
    start_op(pt_tab[4], key_tab[4]);
    wait_run(ok);
    repeat (2) @(negedge Clk);
    force_done = 1'b1;
    n_valid = 0;
    cap = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) force_done = 1'b0;
      @(negedge Clk);
      if (out_valid) begin
        n_valid++;
        cap = out_ciphertext;
      end
    end
    n_total++; if (n_valid !== 1) $display("FAIL spur_level_count: got %0d captures want 1", n_valid); else n_pass++;
    n_total++; if (cap !== force_ct) $display("FAIL spur_level_ct: got %h want %h", cap, force_ct); else n_pass++;
    $display("spurious_done: captures=%0d ct=%h", n_valid, cap);
    core_stall = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    core_stall = 1'b1;
    out_ready  = 1'b0;
    start_op(pt_tab[5], key_tab[5]);
    wait_run(ok);
`ifdef DES128_TIMEOUT_EN
    n = 0;
    while (!out_valid && n < 200) begin
      n++;
      @(negedge Clk);
    end
    n_total++; if (n !== 64) $display("FAIL to_run_cycles: got %0d want 64", n); else n_pass++;
    n_total++; if (timeout_err !== 1'b1 || out_valid !== 1'b1 || out_ciphertext !== 128'h0)
      $display("FAIL to_flag: got err %0b valid %0b ct %h want 1 1 0", timeout_err, out_valid, out_ciphertext); else n_pass++;
    out_ready = 1'b1;
    repeat (4) @(negedge Clk);
    n_total++; if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL to_sticky: got err %0b busy %0b want 1 0", timeout_err, busy); else n_pass++;
    pulse_reset();
    n_total++; if (timeout_err !== 1'b0) $display("FAIL to_clear: got %0b want 0", timeout_err); else n_pass++;
    $display("timeout: run cycles=%0d", n);
`else
    n = 0;
    repeat (100) begin
      @(negedge Clk);
      n++;
    end
    n_total++; if (busy !== 1'b1 || out_valid !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL no_timeout_wait: got busy %0b valid %0b err %0b want 1 0 0", busy, out_valid, timeout_err); else n_pass++;
    pulse_reset();
    n_total++; if (busy !== 1'b0) $display("FAIL no_timeout_reset: got busy %0b want 0", busy); else n_pass++;
    $display("no_timeout: still waiting after %0d cycles", n);
`endif
    core_stall = 1'b0;
    out_ready  = 1'b1;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    Reset        = 1'b1;
    in_valid     = 1'b0;
    in_plaintext = '0;
    in_key       = '0;
    out_ready    = 1'b0;
    core_stall   = 1'b0;
    force_done   = 1'b0;
    force_ct     = '0;
    pt_tab[0] = 128'h80808080808080808080808080808080; key_tab[0] = 128'hE00A6E5724C52BC352DEC4F83972E00A;
    pt_tab[1] = 128'h40404040404040404040404040404040; key_tab[1] = 128'h0123456789ABCDEF0123456789ABCDEF;
    pt_tab[2] = 128'h20202020202020202020202020202020; key_tab[2] = 128'h133457799BBCDFF1133457799BBCDFF1;
    pt_tab[3] = 128'h10101010101010101010101010101010; key_tab[3] = 128'h0E329232EA6D0D730E329232EA6D0D73;
    pt_tab[4] = 128'h08080808080808080808080808080808; key_tab[4] = 128'h7CA110454A1A6E577CA110454A1A6E57;
    pt_tab[5] = 128'h04040404040404040404040404040404; key_tab[5] = 128'h0131D9619DC1376E0131D9619DC1376E;
    pt_tab[6] = 128'h02020202020202020202020202020202; key_tab[6] = 128'h07A1133E4A0B268607A1133E4A0B2686;
    pt_tab[7] = 128'h01010101010101010101010101010101; key_tab[7] = 128'h3849674C2602319E3849674C2602319E;
    pt_tab[8] = 128'h00800080008000800080008000800080; key_tab[8] = 128'h04B915BA43FEB5B604B915BA43FEB5B6;
    pt_tab[9] = 128'h00400040004000400040004000400040; key_tab[9] = 128'h0113B970FD34F2CE0113B970FD34F2CE;
    @(negedge Clk);
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_spurious_done();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
